// File: rtl/mem_arbiter_rr_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr_pkg
//   Shared types and helpers for the physical-memory arbiter.
//   - arb_state_t : arbiter FSM state (idle / transaction in flight)
//   - id_width()  : width of a channel index, never less than 1 bit
// ---------------------------------------------------------------------------
package mem_arbiter_rr_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr_if
//   Bundles the L1-channel request/response signals and the downstream
//   memory port of the arbiter.
//   Modports:
//     master - the arbiter: takes channel requests and downstream responses,
//              drives downstream commands, channel responses and status.
//     slave  - the surrounding system (caches + memory): the mirror image.
//   Signals:
//     ch_read/ch_write   per-channel request, held until its ch_resp
//     ch_address/wdata   packed per channel, channel i at [i*W +: W]
//     ch_resp            one-hot completion to the granted channel
//     ch_rdata           read line broadcast to all channels
//     mem_*              downstream command / completion
//     busy, grant_id     status of the current transaction
// ---------------------------------------------------------------------------
interface mem_arbiter_rr_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 128
);
    localparam int unsigned ID_W = mem_arbiter_rr_pkg::id_width(NUM_CH);

    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic [DATA_W-1:0]        ch_rdata;

    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_W-1:0]        mem_address;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_resp;
    logic [DATA_W-1:0]        mem_rdata;

    logic                     busy;
    logic [ID_W-1:0]          grant_id;

    modport master (
        input  ch_read, ch_write, ch_address, ch_wdata, mem_resp, mem_rdata,
        output ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata,
               busy, grant_id
    );

    modport slave (
        output ch_read, ch_write, ch_address, ch_wdata, mem_resp, mem_rdata,
        input  ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata,
               busy, grant_id
    );

endinterface

// File: rtl/mem_arbiter_rr_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational winner selection over a request vector.
//   RR_EN=1: search starts at ptr and ascends with wrap modulo NUM_CH.
//   RR_EN=0: lowest requesting index wins, ptr ignored.
//   Ports: req (request vector), ptr (round-robin start),
//          valid (any request), winner (selected index).
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ID_W   = 1,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic              valid,
    output logic [ID_W-1:0]   winner
);

    always_comb begin
        logic        found;
        int unsigned idx;
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            if (RR_EN) begin
                idx = (int'(ptr) + off) % NUM_CH;
            end else begin
                idx = off;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rr
//   N-channel arbiter between the L1 caches and the single downstream memory
//   port. In IDLE it picks one requester (round-robin or fixed priority),
//   latches its command and holds the grant until mem_resp, which is routed
//   combinationally to the granted channel as ch_resp.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - mem_arbiter_rr_if.master (channel requests, downstream port,
//            busy/grant_id status)
// ---------------------------------------------------------------------------
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_rr_if.master bus
);

    localparam int unsigned ID_W = id_width(NUM_CH);

    arb_state_t        state;
    arb_state_t        state_next;

    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   ptr_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [NUM_CH-1:0] req;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic              take;

    assign req  = bus.ch_read | bus.ch_write;
    assign take = (state == ARB_IDLE) && pick_valid;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W),
        .RR_EN  (RR_EN)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (pick_valid)   state_next = ARB_BUSY;
            ARB_BUSY: if (bus.mem_resp) state_next = ARB_IDLE;
            default:                    state_next = ARB_IDLE;
        endcase
    end

    // Command is captured once at grant; ch_* changes during BUSY are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            ptr_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            grant_q <= pick_id;
            // Write takes precedence when a channel raises both strobes.
            wr_q    <= bus.ch_write[pick_id];
            rd_q    <= ~bus.ch_write[pick_id];
            addr_q  <= bus.ch_address[int'(pick_id)*ADDR_W +: ADDR_W];
            wdata_q <= bus.ch_wdata[int'(pick_id)*DATA_W +: DATA_W];
            if (RR_EN) begin
                ptr_q <= (pick_id == ID_W'(NUM_CH - 1)) ? '0 : pick_id + 1'b1;
            end
        end
    end

    // Strobes are qualified by BUSY so they fall with the state on
    // completion or reset without a separate clear path.
    always_comb begin
        bus.ch_resp = '0;
        if (state == ARB_BUSY && bus.mem_resp) begin
            bus.ch_resp[grant_q] = 1'b1;
        end
    end

    assign bus.mem_read    = rd_q && (state == ARB_BUSY);
    assign bus.mem_write   = wr_q && (state == ARB_BUSY);
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.ch_rdata    = bus.mem_rdata;
    assign bus.busy        = (state == ARB_BUSY);
    assign bus.grant_id    = grant_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rr
//   Self-checking bench: a 4-channel round-robin instance driven from a
//   vector table plus hand-written corner sequences, and a 2-channel
//   fixed-priority instance for the single-read and priority cases.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_arbiter_rr_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(128)) if4 ();
    mem_arbiter_rr_if #(.NUM_CH(2), .ADDR_W(16), .DATA_W(128)) if2 ();

    mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(16), .DATA_W(128), .RR_EN(1'b1)) u_rr4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.master)
    );

    mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(16), .DATA_W(128), .RR_EN(1'b0)) u_fp2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.master)
    );

    logic [15:0]  addr4  [4];
    logic [127:0] wdata4 [4];
    assign if4.ch_address = {addr4[3], addr4[2], addr4[1], addr4[0]};
    assign if4.ch_wdata   = {wdata4[3], wdata4[2], wdata4[1], wdata4[0]};

    logic saw_resp0 = 1'b0;
    always @(posedge clk or negedge clk) begin
        if (if2.ch_resp[0]) saw_resp0 <= 1'b1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic [1:0] gid;
        logic       er;
        logic       ew;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [127:0] rdat;
        logic [3:0]   onehot;

        // ptr starts at 0; each comment shows ptr after the grant
        tbl[0] = '{4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0}; // ptr 2
        tbl[1] = '{4'b0011, 4'b0000, 2'd0, 1'b1, 1'b0}; // wrap 2,3,0 -> ptr 1
        tbl[2] = '{4'b0011, 4'b0000, 2'd1, 1'b1, 1'b0}; // ptr 2
        tbl[3] = '{4'b0001, 4'b1000, 2'd3, 1'b0, 1'b1}; // ptr 0 (wrap)
        tbl[4] = '{4'b0101, 4'b0000, 2'd0, 1'b1, 1'b0}; // after grant 3: 0 next
        tbl[5] = '{4'b0101, 4'b0000, 2'd2, 1'b1, 1'b0}; // then 2, ptr 3
        tbl[6] = '{4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1}; // read+write -> write, ptr 3
        tbl[7] = '{4'b1111, 4'b0000, 2'd3, 1'b1, 1'b0}; // ptr 0
        tbl[8] = '{4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0}; // ptr 1

        addr4[0] = 16'h1230; addr4[1] = 16'h1231; addr4[2] = 16'h1232; addr4[3] = 16'h1233;
        wdata4[0] = {8{16'h1111}}; wdata4[1] = {8{16'h2222}};
        wdata4[2] = {8{16'hDEAD}}; wdata4[3] = {8{16'h4444}};
        if4.ch_read = '0; if4.ch_write = '0; if4.mem_resp = 1'b0; if4.mem_rdata = '0;
        if2.ch_read = '0; if2.ch_write = '0; if2.mem_resp = 1'b0; if2.mem_rdata = '0;
        if2.ch_address = '0; if2.ch_wdata = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",     if4.busy,        1'b0);
        check("rst_mem_read", if4.mem_read,    1'b0);
        check("rst_mem_wr",   if4.mem_write,   1'b0);
        check("rst_addr",     if4.mem_address, 16'h0);
        check("rst_wdata",    if4.mem_wdata,   128'h0);
        check("rst_grant",    if4.grant_id,    2'd0);
        check("rst_ch_resp",  if4.ch_resp,     4'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven round-robin sequence ----------------
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            if4.ch_read  = tbl[v].rd;
            if4.ch_write = tbl[v].wr;
            @(posedge clk); #1;
            check("tbl_busy",  if4.busy,        1'b1);
            check("tbl_grant", if4.grant_id,    tbl[v].gid);
            check("tbl_rd",    if4.mem_read,    tbl[v].er);
            check("tbl_wr",    if4.mem_write,   tbl[v].ew);
            check("tbl_addr",  if4.mem_address, addr4[tbl[v].gid]);
            check("tbl_wdata", if4.mem_wdata,   wdata4[tbl[v].gid]);
            @(negedge clk);
            @(negedge clk);
            rdat = {8{16'h5A00 + 16'(v)}};
            if4.mem_resp  = 1'b1;
            if4.mem_rdata = rdat;
            #1;
            onehot = 4'b0001 << tbl[v].gid;
            check("tbl_ch_resp", if4.ch_resp,  onehot);
            check("tbl_rdata",   if4.ch_rdata, rdat);
            @(posedge clk); #1;
            if4.mem_resp = 1'b0;
            if4.ch_read  = '0;
            if4.ch_write = '0;
            check("tbl_idle", if4.busy,     1'b0);
            check("tbl_rd_0", if4.mem_read, 1'b0);
        end

        // ---------------- address change during BUSY (ptr 1 -> grant 1) ----------------
        @(negedge clk);
        addr4[1] = 16'h4000;
        if4.ch_read = 4'b0010;
        @(posedge clk); #1;
        check("chg_addr_grant", if4.mem_address, 16'h4000);
        @(negedge clk);
        addr4[1] = 16'h5000;
        if4.ch_read = 4'b0000;
        @(posedge clk); #1;
        check("chg_addr_hold", if4.mem_address, 16'h4000);
        check("chg_busy",      if4.busy,        1'b1);
        check("chg_rd",        if4.mem_read,    1'b1);
        @(negedge clk);
        if4.mem_resp = 1'b1;
        #1;
        check("chg_ch_resp", if4.ch_resp, 4'b0010);
        @(posedge clk); #1;
        if4.mem_resp = 1'b0;
        addr4[1] = 16'h1231;

        // ---------------- mem_resp while IDLE ignored ----------------
        @(negedge clk);
        if4.mem_resp = 1'b1;
        #1;
        check("idle_resp_ch_resp", if4.ch_resp, 4'b0);
        @(posedge clk); #1;
        check("idle_resp_busy", if4.busy, 1'b0);
        if4.mem_resp = 1'b0;

        // ---------------- reset mid-BUSY (ptr 2 -> grant 2, ptr 3) ----------------
        @(negedge clk);
        if4.ch_read = 4'b0100;
        @(posedge clk); #1;
        check("rstb_grant", if4.grant_id, 2'd2);
        @(negedge clk);
        if4.ch_read = 4'b0000;
        rst = 1'b1;
        #1;
        check("rstb_busy",  if4.busy,        1'b0);
        check("rstb_rd",    if4.mem_read,    1'b0);
        check("rstb_grant0", if4.grant_id,   2'd0);
        check("rstb_addr",  if4.mem_address, 16'h0);
        check("rstb_wdata", if4.mem_wdata,   128'h0);
        @(negedge clk);
        rst = 1'b0;
        if4.mem_resp = 1'b1;
        #1;
        check("rstb_late_resp", if4.ch_resp, 4'b0);
        @(posedge clk); #1;
        if4.mem_resp = 1'b0;
        check("rstb_stay_idle", if4.busy, 1'b0);
        // ptr reset to 0 -> channel 2 wins over 3 (ptr 3 would pick 3)
        @(negedge clk);
        if4.ch_read = 4'b1100;
        @(posedge clk); #1;
        check("rstb_ptr0", if4.grant_id, 2'd2);
        @(negedge clk);
        if4.mem_resp = 1'b1;
        @(posedge clk); #1;
        if4.mem_resp = 1'b0;
        if4.ch_read  = 4'b0000;

        // ---------------- 2-channel fixed priority: single read ----------------
        @(negedge clk);
        if2.ch_address = {16'h1230, 16'h0000};
        if2.ch_read    = 2'b10;
        @(posedge clk); #1;
        check("fp_single_rd",    if2.mem_read,    1'b1);
        check("fp_single_wr",    if2.mem_write,   1'b0);
        check("fp_single_addr",  if2.mem_address, 16'h1230);
        check("fp_single_grant", if2.grant_id,    1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        if2.mem_resp  = 1'b1;
        if2.mem_rdata = {16{8'hA5}};
        #1;
        check("fp_single_resp",  if2.ch_resp,  2'b10);
        check("fp_single_rdata", if2.ch_rdata, {16{8'hA5}});
        @(posedge clk); #1;
        if2.mem_resp = 1'b0;
        if2.ch_read  = 2'b00;
        check("fp_no_resp0", saw_resp0, 1'b0);

        // ---------------- 2-channel fixed priority: both requesting ----------------
        @(negedge clk);
        if2.ch_address = {16'h2222, 16'h1111};
        if2.ch_read    = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("fp_both_grant", if2.grant_id,    1'b0);
            check("fp_both_addr",  if2.mem_address, 16'h1111);
            @(negedge clk);
            if2.mem_resp = 1'b1;
            #1;
            check("fp_both_resp", if2.ch_resp, 2'b01);
            @(posedge clk); #1;
            if2.mem_resp = 1'b0;
            check("fp_both_idle", if2.busy, 1'b0);
        end
        if2.ch_read = 2'b00;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
